// File: rtl/pregfile_pkg.sv
// Shared constants, clear-FSM state type and register-class helpers for the
// register file with input-mapped and reserved entries.
package pregfile_pkg;

    localparam int ZERO_REG = 32'd31;
    localparam int XP_REG   = 32'd30;
    localparam int BP_REG   = 32'd27;
    localparam int LP_REG   = 32'd28;
    localparam int SP_REG   = 32'd29;
    localparam int IN_UI_LO = 32'd24;
    localparam int IN_UI_HI = 32'd25;
    localparam int IN_PSEL  = 32'd26;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Input-mapped entries are owned by the synchronizers, never by writes or clear.
    function automatic logic is_input_reg(input int addr);
        return (addr >= IN_UI_LO) && (addr <= IN_PSEL);
    endfunction

    function automatic logic is_zero_reg(input int addr);
        return addr == ZERO_REG;
    endfunction

endpackage

// File: rtl/pregfile_in_sync.sv
// Two-flop synchronizer for asynchronous switch/selector inputs, with a
// synchronous active-high reset.
module in_sync #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Metastability-settling stage followed by the stable output stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pregfile.sv
// Multi-port register file with write bypass, protected entries, input-mapped
// registers, a sequential clear engine and a nibble display tap.
module pregfile
    import pregfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int DISP_N = 8,
    parameter int DISP_W = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NRD*AW-1:0]       rd_addr,
    output logic [NRD*WIDTH-1:0]    rd_data,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic                    xp_sel,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    clear_req,
    output logic                    busy,
    output logic                    wr_err,
    input  logic [15:0]             user_input,
    input  logic [WIDTH-1:0]        program_selector,
    output logic [DISP_N*DISP_W-1:0] disp_data
);

    localparam int            DEPTH    = 32'd1 << AW;
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    clr_state_e       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             wr_err_q;

    logic [AW-1:0]    eff_addr_s;
    logic             wr_acc_s;
    logic             wr_rej_s;
    logic [15:0]      ui_sync_s;
    logic [WIDTH-1:0] ps_sync_s;
    logic             unused_ui_msb_s;

    in_sync #(.W(16)) u_ui_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (user_input),
        .q_o   (ui_sync_s)
    );

    in_sync #(.W(WIDTH)) u_ps_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (program_selector),
        .q_o   (ps_sync_s)
    );

    assign unused_ui_msb_s = ui_sync_s[15];

    // Write target resolution and acceptance; ZERO_REG writes vanish silently.
    always_comb begin
        eff_addr_s = xp_sel ? AW'(XP_REG) : wr_addr;
        wr_acc_s   = wr_en && (state_q == IDLE)
                     && !is_zero_reg(int'(eff_addr_s))
                     && !is_input_reg(int'(eff_addr_s));
        wr_rej_s   = wr_en && !wr_acc_s && !is_zero_reg(int'(eff_addr_s));
    end

    // Clear FSM next-state: one entry per cycle, DEPTH cycles in CLEAR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, counter and rejected-write pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_err_q <= wr_rej_s;
        end
    end

    // Storage array: writes, clear sweep, and per-cycle input-mapped loads.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_acc_s) begin
                mem_q[eff_addr_s] <= wr_data;
            end
            if ((state_q == CLEAR) && !is_input_reg(int'(cnt_q))) begin
                mem_q[cnt_q] <= '0;
            end
            mem_q[IN_UI_LO] <= {{(WIDTH-8){1'b0}}, ui_sync_s[7:0]};
            mem_q[IN_UI_HI] <= {{(WIDTH-7){1'b0}}, ui_sync_s[14:8]};
            mem_q[IN_PSEL]  <= ps_sync_s;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    ra_s;
        logic [WIDTH-1:0] rd_s;

        assign ra_s = rd_addr[k*AW +: AW];

        // Combinational read with same-cycle bypass of an accepted write.
        always_comb begin
            if (wr_acc_s && (ra_s == eff_addr_s)) begin
                rd_s = wr_data;
            end else if (is_zero_reg(int'(ra_s))) begin
                rd_s = '0;
            end else begin
                rd_s = mem_q[ra_s];
            end
        end

        assign rd_data[k*WIDTH +: WIDTH] = rd_s;
    end

    // Display tap: low nibble of each of the first DISP_N entries, reg0 lowest.
    always_comb begin
        disp_data = '0;
        for (int i = 0; i < DISP_N; i++) begin
            disp_data[i*DISP_W +: DISP_W] = mem_q[i][DISP_W-1:0];
        end
    end

    assign busy   = (state_q == CLEAR);
    assign wr_err = wr_err_q;

endmodule
